// File: rtl/chip8_keypad_scanner_pkg.sv
// Shared keypad constants for the CHIP-8 core: matrix geometry, key index width
// and the default matrix polarity.
package chip8_keypad_scanner_pkg;

  localparam int unsigned KEY_ROWS          = 4;
  localparam int unsigned KEY_COLS          = 4;
  localparam int unsigned KEY_COUNT         = KEY_ROWS * KEY_COLS;
  localparam int unsigned KEY_IDX_W         = $clog2(KEY_COUNT);
  localparam bit          MATRIX_ACTIVE_LOW = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip8_keypad_scanner_if.sv
// Keypad scanner bundle: matrix drive/sense plus the one-entry key-press event port.
interface chip8_keypad_scanner_if #(
  parameter int unsigned ROWS = chip8_keypad_scanner_pkg::KEY_ROWS,
  parameter int unsigned COLS = chip8_keypad_scanner_pkg::KEY_COLS
);
  localparam int unsigned KW = chip8_keypad_scanner_pkg::idx_w(ROWS * COLS);

  logic [ROWS-1:0]      row_out;
  logic [COLS-1:0]      col_in;
  logic [ROWS*COLS-1:0] keys;
  logic                 key_valid;
  logic [KW-1:0]        key_code;
  logic                 key_ack;

  modport master (
    output row_out, keys, key_valid, key_code,
    input  col_in, key_ack
  );

  modport slave (
    input  row_out, keys, key_valid, key_code,
    output col_in, key_ack
  );
endinterface

// File: rtl/chip8_keypad_scanner_debounce.sv
// Single-key debouncer: the stable bit flips after DEBOUNCE consecutive strobed
// samples that disagree with it; a one-clock rise pulse follows each 0->1 flip.
module chip8_keypad_scanner_debounce
  import chip8_keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sample,
  input  logic i_strobe,
  output logic o_stable,
  output logic o_rise
);
  localparam int unsigned CNT_W = idx_w(DEBOUNCE);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             w_flip;

  assign w_flip = (i_sample != r_stable) && (r_cnt == CNT_W'(DEBOUNCE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (i_strobe) begin
        if (i_sample == r_stable) begin
          r_cnt <= '0;
        end else if (w_flip) begin
          r_cnt    <= '0;
          r_stable <= ~r_stable;
          r_rise   <= ~r_stable;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;

endmodule

// File: rtl/chip8_keypad_scanner.sv
// Keypad matrix scanner: row divider/counter, column synchroniser, per-key
// debounce and a one-entry lowest-index key-press event register.
module chip8_keypad_scanner
  import chip8_keypad_scanner_pkg::*;
#(
  parameter int unsigned ROWS       = KEY_ROWS,
  parameter int unsigned COLS       = KEY_COLS,
  parameter int unsigned SCAN_DIV   = 5000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter bit          ACTIVE_LOW = MATRIX_ACTIVE_LOW
) (
  input  logic                   clk,
  input  logic                   reset,
  chip8_keypad_scanner_if.master kp
);
  localparam int unsigned NKEYS = ROWS * COLS;
  localparam int unsigned DIV_W = idx_w(SCAN_DIV);
  localparam int unsigned ROW_W = idx_w(ROWS);
  localparam int unsigned KW    = idx_w(NKEYS);
  localparam logic [COLS-1:0] COL_IDLE = {COLS{ACTIVE_LOW}};

  logic [DIV_W-1:0] r_div;
  logic [ROW_W-1:0] r_row;
  logic [ROWS-1:0]  r_row_out;
  logic [COLS-1:0]  r_sync1;
  logic [COLS-1:0]  r_sync2;
  logic             r_valid;
  logic [KW-1:0]    r_code;

  logic             w_edge;
  logic [ROW_W-1:0] w_row_nxt;
  logic [COLS-1:0]  w_col;
  logic [NKEYS-1:0] w_keys;
  logic [NKEYS-1:0] w_rise;
  logic [KW-1:0]    w_low;

  function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
    logic [ROWS-1:0] oh;
    oh      = '0;
    oh[row] = 1'b1;
    return ACTIVE_LOW ? ~oh : oh;
  endfunction

  assign w_edge    = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_row_nxt = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
  assign w_col     = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // Row dwell timer; the row drive moves on the same edge that samples the columns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_row     <= '0;
      r_row_out <= row_drive('0);
    end else if (w_edge) begin
      r_div     <= '0;
      r_row     <= w_row_nxt;
      r_row_out <= row_drive(w_row_nxt);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= COL_IDLE;
      r_sync2 <= COL_IDLE;
    end else begin
      r_sync1 <= kp.col_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      chip8_keypad_scanner_debounce #(
        .DEBOUNCE(DEBOUNCE)
      ) u_db (
        .clk      (clk),
        .reset    (reset),
        .i_sample (w_col[c]),
        .i_strobe (w_edge && (r_row == ROW_W'(r))),
        .o_stable (w_keys[r*COLS+c]),
        .o_rise   (w_rise[r*COLS+c])
      );
    end
  end

  always_comb begin
    w_low = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (w_rise[k]) w_low = KW'(k);
    end
  end

  // An ack frees the slot on the same edge, so a coincident press still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else if ((|w_rise) && (!r_valid || kp.key_ack)) begin
      r_valid <= 1'b1;
      r_code  <= w_low;
    end else if (kp.key_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign kp.row_out   = r_row_out;
  assign kp.keys      = w_keys;
  assign kp.key_valid = r_valid;
  assign kp.key_code  = r_code;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Bench for chip8_keypad_scanner: a physical key matrix drives the columns and a
// per-sample reference model predicts keys and the press-event register.
module tb_chip8_keypad_scanner;
  import chip8_keypad_scanner_pkg::*;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 4;
  localparam int unsigned NK       = ROWS * COLS;
  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEBOUNCE = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  chip8_keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kp();

  chip8_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its column low while its row is driven low.
  logic [NK-1:0] pressed;
  always_comb begin
    kp.col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!kp.row_out[r] && pressed[r*COLS+c]) kp.col_in[c] = 1'b0;
  end

  int unsigned   cyc;
  logic [NK-1:0] m_keys;
  logic [NK-1:0] m_rise;
  int unsigned   m_cnt [NK];
  logic          m_valid;
  logic [3:0]    m_code;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic [3:0] lowest(input logic [NK-1:0] v);
    for (int k = 0; k < NK; k++) if (v[k]) return 4'(k);
    return 4'd0;
  endfunction

  function automatic logic [3:0] exp_row_out(input int unsigned c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((c / SCAN_DIV) % ROWS));
  endfunction

  task automatic model_clear();
    m_keys  = '0;
    m_rise  = '0;
    m_valid = 1'b0;
    m_code  = 4'd0;
    for (int k = 0; k < NK; k++) m_cnt[k] = 0;
  endtask

  // One clock: event register reacts to last edge's rises, then the row sample.
  task automatic tick();
    int unsigned row;
    int unsigned k;
    @(posedge clk);
    cyc++;
    if (m_rise != '0 && (!m_valid || kp.key_ack)) begin
      m_valid = 1'b1;
      m_code  = lowest(m_rise);
    end else if (kp.key_ack && m_valid) begin
      m_valid = 1'b0;
    end
    m_rise = '0;
    if (cyc % SCAN_DIV == 0) begin
      row = (cyc / SCAN_DIV - 1) % ROWS;
      for (int c = 0; c < COLS; c++) begin
        k = row * COLS + c;
        if (pressed[k] == m_keys[k]) m_cnt[k] = 0;
        else begin
          m_cnt[k]++;
          if (m_cnt[k] == DEBOUNCE) begin
            m_keys[k] = ~m_keys[k];
            m_cnt[k]  = 0;
            if (m_keys[k]) m_rise[k] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic to_edge();
    do tick(); while (cyc % SCAN_DIV != 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    kp.key_ack = 1'b0;
    pressed = '0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    kp.key_ack = 1'b0;
    pressed = '0;
    model_clear();
    #2 reset = 1'b1;
    #3;
    n_cmp++; if (kp.row_out !== 4'b1110) begin n_err++; $display("FAIL reset_row_out: got %b expected 1110", kp.row_out); end
    n_cmp++; if (kp.keys !== 16'h0000) begin n_err++; $display("FAIL reset_keys: got %h expected 0000", kp.keys); end
    n_cmp++; if (kp.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", kp.key_valid); end
    n_cmp++; if (kp.key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d expected 0", kp.key_code); end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    repeat (7) tick();
    n_cmp++; if (kp.row_out !== 4'b1110) begin n_err++; $display("FAIL row_hold: got %b expected 1110", kp.row_out); end
    tick();
    n_cmp++; if (kp.row_out !== 4'b1101) begin n_err++; $display("FAIL row_advance: got %b expected 1101", kp.row_out); end
  endtask

  task automatic test_press_ack();
    pressed[5] = 1'b1;
    while (cyc < 80) begin
      tick();
      n_cmp++;
      if (kp.keys !== m_keys || kp.key_valid !== m_valid) begin
        n_err++;
        $display("FAIL press_track cyc=%0d: got keys=%h valid=%b expected keys=%h valid=%b", cyc, kp.keys, kp.key_valid, m_keys, m_valid);
      end
    end
    n_cmp++; if (kp.keys !== 16'h0020) begin n_err++; $display("FAIL press_keys: got %h expected 0020", kp.keys); end
    n_cmp++; if (kp.key_valid !== 1'b0) begin n_err++; $display("FAIL press_valid_early: got %b expected 0", kp.key_valid); end
    tick();
    n_cmp++; if (kp.key_valid !== 1'b1) begin n_err++; $display("FAIL press_valid: got %b expected 1", kp.key_valid); end
    n_cmp++; if (kp.key_code !== 4'd5) begin n_err++; $display("FAIL press_code: got %0d expected 5", kp.key_code); end
    kp.key_ack = 1'b1;
    tick();
    kp.key_ack = 1'b0;
    n_cmp++; if (kp.key_valid !== 1'b0) begin n_err++; $display("FAIL ack_clear: got %b expected 0", kp.key_valid); end
  endtask

  task automatic test_release_and_bounce();
    to_edge();
    pressed[5] = 1'b0;
    while (cyc < 176) begin
      tick();
      n_cmp++;
      if (kp.key_valid !== 1'b0 || kp.keys !== m_keys) begin
        n_err++;
        $display("FAIL release_track cyc=%0d: got keys=%h valid=%b expected keys=%h valid=0", cyc, kp.keys, kp.key_valid, m_keys);
      end
    end
    n_cmp++; if (kp.keys !== 16'h0000) begin n_err++; $display("FAIL release_keys: got %h expected 0000", kp.keys); end
    pressed[5] = 1'b1;
    while (cyc < 240) tick();
    pressed[5] = 1'b0;
    while (cyc < 312) begin
      tick();
      n_cmp++;
      if (kp.keys !== 16'h0000 || kp.key_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bounce cyc=%0d: got keys=%h valid=%b expected keys=0000 valid=0", cyc, kp.keys, kp.key_valid);
      end
    end
  endtask

  task automatic test_pending_drop();
    int guard;
    to_edge();
    pressed[5] = 1'b1;
    guard = 0;
    while (!m_valid && guard < 150) begin tick(); guard++; end
    n_cmp++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd5) begin n_err++; $display("FAIL pend_first: got valid=%b code=%0d expected valid=1 code=5", kp.key_valid, kp.key_code); end
    to_edge();
    pressed[9] = 1'b1;
    repeat (128) begin
      tick();
      n_cmp++;
      if (kp.keys !== m_keys || kp.key_valid !== m_valid) begin
        n_err++;
        $display("FAIL pend_track cyc=%0d: got keys=%h valid=%b expected keys=%h valid=%b", cyc, kp.keys, kp.key_valid, m_keys, m_valid);
      end
    end
    n_cmp++; if (kp.keys !== 16'h0220) begin n_err++; $display("FAIL pend_keys: got %h expected 0220", kp.keys); end
    n_cmp++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd5) begin n_err++; $display("FAIL pend_hold: got valid=%b code=%0d expected valid=1 code=5", kp.key_valid, kp.key_code); end
    kp.key_ack = 1'b1;
    tick();
    kp.key_ack = 1'b0;
    repeat (64) begin
      tick();
      n_cmp++; if (kp.key_valid !== 1'b0) begin n_err++; $display("FAIL pend_dropped cyc=%0d: got valid=%b expected 0", cyc, kp.key_valid); end
    end
    to_edge();
    pressed = '0;
    repeat (128) tick();
    n_cmp++; if (kp.keys !== 16'h0000 || kp.key_valid !== 1'b0) begin n_err++; $display("FAIL pend_release: got keys=%h valid=%b expected keys=0000 valid=0", kp.keys, kp.key_valid); end
  endtask

  task automatic test_priority_ack_collision();
    int guard;
    to_edge();
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    guard = 0;
    while (!m_valid && guard < 150) begin tick(); guard++; end
    n_cmp++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd4) begin n_err++; $display("FAIL prio_code: got valid=%b code=%0d expected valid=1 code=4", kp.key_valid, kp.key_code); end
    n_cmp++; if (kp.keys !== 16'h0050) begin n_err++; $display("FAIL prio_keys: got %h expected 0050", kp.keys); end
    to_edge();
    pressed[13] = 1'b1;
    guard = 0;
    while (!m_rise[13] && guard < 150) begin tick(); guard++; end
    n_cmp++; if (kp.keys !== 16'h2050) begin n_err++; $display("FAIL coll_keys: got %h expected 2050", kp.keys); end
    kp.key_ack = 1'b1;
    tick();
    kp.key_ack = 1'b0;
    n_cmp++; if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd13) begin n_err++; $display("FAIL coll_latch: got valid=%b code=%0d expected valid=1 code=13", kp.key_valid, kp.key_code); end
    kp.key_ack = 1'b1;
    tick();
    kp.key_ack = 1'b0;
    n_cmp++; if (kp.key_valid !== 1'b0) begin n_err++; $display("FAIL coll_ack: got %b expected 0", kp.key_valid); end
    to_edge();
    pressed = '0;
    repeat (128) tick();
    n_cmp++; if (kp.keys !== 16'h0000 || kp.key_valid !== 1'b0) begin n_err++; $display("FAIL coll_release: got keys=%h valid=%b expected keys=0000 valid=0", kp.keys, kp.key_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1600; i++) begin
      if (cyc % SCAN_DIV == 0 && $urandom_range(3) == 0) pressed[$urandom_range(NK - 1)] ^= 1'b1;
      kp.key_ack = ($urandom_range(5) == 0);
      tick();
      n_cmp++;
      if (kp.keys !== m_keys || kp.key_valid !== m_valid || (m_valid && kp.key_code !== m_code)) begin
        n_err++;
        $display("FAIL random cyc=%0d: got keys=%h valid=%b code=%0d expected keys=%h valid=%b code=%0d", cyc, kp.keys, kp.key_valid, kp.key_code, m_keys, m_valid, m_code);
      end
      n_cmp++;
      if (kp.row_out !== exp_row_out(cyc)) begin
        n_err++;
        $display("FAIL random_row cyc=%0d: got %b expected %b", cyc, kp.row_out, exp_row_out(cyc));
      end
    end
    kp.key_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard;
    apply_reset();
    to_edge();
    pressed[5] = 1'b1;
    guard = 0;
    while (!m_valid && guard < 150) begin tick(); guard++; end
    n_cmp++; if (kp.keys !== 16'h0020 || kp.key_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got keys=%h valid=%b expected keys=0020 valid=1", kp.keys, kp.key_valid); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (kp.row_out !== 4'b1110) begin n_err++; $display("FAIL areset_row: got %b expected 1110", kp.row_out); end
    n_cmp++; if (kp.keys !== 16'h0000) begin n_err++; $display("FAIL areset_keys: got %h expected 0000", kp.keys); end
    n_cmp++; if (kp.key_valid !== 1'b0 || kp.key_code !== 4'd0) begin n_err++; $display("FAIL areset_event: got valid=%b code=%0d expected valid=0 code=0", kp.key_valid, kp.key_code); end
    pressed = '0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    repeat (8) tick();
    n_cmp++; if (kp.row_out !== 4'b1101) begin n_err++; $display("FAIL areset_restart: got %b expected 1101", kp.row_out); end
  endtask

  initial begin
    pressed    = '0;
    kp.key_ack = 1'b0;
    cyc        = 0;
    test_reset();
    test_press_ack();
    test_release_and_bounce();
    test_pending_drop();
    test_priority_ack_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
